// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver: oversamples SCK/WS/SD on the system clock and
// deserialises each slot into an MSB-aligned WIDTH-bit word, emitting registered stereo pairs.
module i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int JUSTIFY = 0,
  parameter int SYNC    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       i2s,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  output logic             short_word
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] TOP  = CW'(WIDTH - 1);

  typedef enum logic {SEEK, RUN} state_t;

  state_t           state, state_next;
  logic [2:0]       sync_q [SYNC];
  logic             sck_s, ws_s, sd_s;
  logic             sck_prev, ws_d, eff_prev, primed, pair;
  logic             ckp, eff_ws, boundary, store;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;

  // All three bus bits share one synchroniser chain so they stay mutually aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i2s;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sck_s    = sync_q[SYNC-1][0];
  assign ws_s     = sync_q[SYNC-1][1];
  assign sd_s     = sync_q[SYNC-1][2];
  assign ckp      = sck_s & ~sck_prev;
  assign eff_ws   = (JUSTIFY != 0) ? ws_s : ws_d;
  assign boundary = ckp & primed & (eff_ws != eff_prev);

  always_ff @(posedge clock) begin
    if (reset) state <= SEEK;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    store      = 1'b0;
    case (state)
      SEEK:    if (boundary) state_next = RUN;
      RUN:     store = boundary;
      default: state_next = SEEK;
    endcase
  end

  // Bits land MSB-first; positions are written once per slot, so OR-ing into sr is safe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_prev <= 1'b0;
      ws_d     <= 1'b0;
      eff_prev <= 1'b0;
      primed   <= 1'b0;
      sr       <= '0;
      count    <= '0;
    end else begin
      sck_prev <= sck_s;
      if (ckp) begin
        ws_d     <= ws_s;
        eff_prev <= eff_ws;
        primed   <= 1'b1;
        if (boundary) begin
          sr    <= WIDTH'(sd_s) << TOP;
          count <= CW'(1);
        end else if (count < FULL) begin
          sr    <= sr | (WIDTH'(sd_s) << (TOP - count));
          count <= count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      left       <= '0;
      right      <= '0;
      valid      <= 1'b0;
      short_word <= 1'b0;
      pair       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      short_word <= 1'b0;
      if (store) begin
        if (!eff_prev) begin
          left <= sr;
          pair <= 1'b1;
        end else begin
          right <= sr;
          if (pair) begin
            valid <= 1'b1;
            pair  <= 1'b0;
          end
        end
        short_word <= (count < FULL);
      end
    end
  end

endmodule
